// File: rtl/lsu_defs_pkg.sv
// Load/store shared definitions: access-type codes and the byte-mask helper
// used by both the load extension path and the store align buffer.
package lsu_defs_pkg;

    typedef enum logic [2:0] {
        LS_B  = 3'b000,  // SB / LB
        LS_H  = 3'b001,  // SH / LH
        LS_W  = 3'b010,  // SW / LW
        LS_BU = 3'b100,  // LBU
        LS_HU = 3'b101   // LHU
    } ls_type_e;

    // Byte lanes touched by an access of the given type at byte offset off.
    function automatic logic [3:0] byte_mask(input logic [2:0] ls_type, input logic [1:0] off);
        logic [3:0] mask;
        case (ls_type)
            LS_B, LS_BU: mask = 4'b0001 << off;
            LS_H, LS_HU: mask = 4'b0011 << off;
            LS_W:        mask = 4'b1111;
            default:     mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// In-order store buffer storage: DEPTH entries of W bits with read/write
// pointers, occupancy count and a per-entry valid vector for hazard lookup.
module sb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 66
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic                     full,
    output logic                     empty,
    output logic [W-1:0]             ent_data [DEPTH],
    output logic [DEPTH-1:0]         ent_vld
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // Entry payload storage, written at the tail on push.
    // NOTE: the data array has no reset; validity is carried by ent_vld/count,
    // so stale payload is never observed and the RAM stays reset-free.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and per-entry valid bits.
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ent_vld <= '0;
        end else begin
            if (push) begin
                wr_ptr          <= wr_ptr + PTR_ONE;
                ent_vld[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr          <= rd_ptr + PTR_ONE;
                ent_vld[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];
    assign ent_data  = mem;

endmodule

// File: rtl/store_align_buffer.sv
// Store align buffer: aligns MEM-stage store data to byte lanes, builds
// strobes, rejects illegal/misaligned stores and queues legal ones in order
// for the data-memory write port.
// Optional feature macro: STORE_LD_HAZARD_EN enables the load/pending-store
// overlap compare on ld_hazard_M; otherwise ld_hazard_M is tied low.
module store_align_buffer
    import lsu_defs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st_valid_M,
    output logic          st_ready_M,
    input  logic [AW-1:0] st_addr_M,
    input  logic [31:0]   st_data_M,
    input  logic [2:0]    ls_type_M,
    output logic          st_misalign_err,
    output logic          mem_req,
    input  logic          mem_gnt,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    output logic          sb_empty,
    input  logic          ld_check_M,
    input  logic [AW-1:0] ld_addr_M,
    input  logic [2:0]    ld_type_M,
    output logic          ld_hazard_M
);

    // Entry layout: {word address, lane-aligned data, strobes}
    localparam int EW = (AW - 2) + 32 + 4;

    logic [1:0]    st_off;
    logic          st_legal;
    logic [31:0]   st_wdata;
    logic [3:0]    st_wstrb;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [EW-1:0] head_data;
    logic [EW-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0] ent_vld;

    assign st_off = st_addr_M[1:0];

    // Legality check and lane replication of the store data.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        st_legal = 1'b0;
        st_wdata = '0;
        case (ls_type_M)
            LS_B: begin
                st_legal = 1'b1;
                st_wdata = {4{st_data_M[7:0]}};
            end
            LS_H: begin
                st_legal = ~st_off[0];
                st_wdata = {2{st_data_M[15:0]}};
            end
            LS_W: begin
                st_legal = (st_off == 2'b00);
                st_wdata = st_data_M;
            end
            default: begin
                st_legal = 1'b0;
                st_wdata = '0;
            end
        endcase
    end

    assign st_wstrb   = byte_mask(ls_type_M, st_off);
    assign st_ready_M = ~fifo_full;
    assign push       = st_valid_M & st_ready_M & st_legal;
    assign mem_req    = ~fifo_empty;
    assign pop        = mem_req & mem_gnt;
    assign sb_empty   = fifo_empty;

    sb_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_sb_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({st_addr_M[AW-1:2], st_wdata, st_wstrb}),
        .pop       (pop),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .ent_data  (ent_data),
        .ent_vld   (ent_vld)
    );

    // Head entry presented to memory; zero whenever nothing is pending.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (mem_req) begin
            mem_addr  = {head_data[EW-1:36], 2'b00};
            mem_wdata = head_data[35:4];
            mem_wstrb = head_data[3:0];
        end
    end

    // One-cycle error pulse for a rejected store, independent of ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_misalign_err <= 1'b0;
        end else begin
            st_misalign_err <= st_valid_M & ~st_legal;
        end
    end

`ifdef STORE_LD_HAZARD_EN
    logic [3:0] ld_mask;

    // Load overlaps any entry already valid in the buffer (same word, shared lane).
    always_comb begin
        ld_mask     = byte_mask(ld_type_M, ld_addr_M[1:0]);
        ld_hazard_M = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] &&
                (ent_data[i][EW-1:36] == ld_addr_M[AW-1:2]) &&
                ((ent_data[i][3:0] & ld_mask) != 4'b0000)) begin
                ld_hazard_M = 1'b1;
            end
        end
        ld_hazard_M = ld_hazard_M & ld_check_M;
    end
`else
    logic unused_hazard_inputs;

    // Hazard compare compiled out; fold the idle inputs into one sink.
    always_comb begin
        unused_hazard_inputs = ^{ld_check_M, ld_addr_M, ld_type_M, ent_vld};
        for (int i = 0; i < DEPTH; i++) begin
            unused_hazard_inputs = unused_hazard_inputs ^ (^ent_data[i]);
        end
    end

    assign ld_hazard_M = 1'b0;
`endif

endmodule
